// File: rtl/bids_cmd_sequencer_if.sv
// Host command, bid-controller and completion signals of the command sequencer.
// The sequencer connects through the slave modport; its environment uses the master modport.
interface bids_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        cmd_start;

  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic        ready;
  logic [2:0]  err;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_op;
  logic [2:0]  rsp_err;

  logic        busy;
  logic [15:0] issued_cnt;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_start, ready, err, rsp_ready,
    output cmd_ready, C_op, C_data, C_start, rsp_valid, rsp_op, rsp_err, busy, issued_cnt
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_start, ready, err, rsp_ready,
    input  cmd_ready, C_op, C_data, C_start, rsp_valid, rsp_op, rsp_err, busy, issued_cnt
  );
endinterface

// File: rtl/bids_cmd_sequencer.sv
// Queues host commands and issues them one at a time to the bid controller,
// waiting for completion (or a timeout) and returning a completion record.
module bids_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [3:0]  NOP_OP     = 4'hF
) (
  input  logic                 clk,
  input  logic                 reset,
  bids_cmd_sequencer_if.slave  bus
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]        ERR_TIMEOUT = 3'b111;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] data;
    logic        start;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  cmd_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  cmd_t             head;
  cmd_t             cmd_in;

  logic [3:0]        c_op_q, c_op_d;
  logic [31:0]       c_data_q, c_data_d;
  logic              c_start_q, c_start_d;
  logic [3:0]        op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [3:0]        rsp_op_q, rsp_op_d;
  logic [2:0]        rsp_err_q, rsp_err_d;
  logic [15:0]       issued_cnt_q, issued_cnt_d;

  assign fifo_full  = (fifo_cnt_q == FIFO_FULL);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign push       = bus.cmd_valid && !fifo_full;
  assign head       = mem[rd_ptr_q];
  assign cmd_in     = '{op: bus.cmd_op, data: bus.cmd_data, start: bus.cmd_start};

  // Queue storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= cmd_in;
    end
  end

  // Queue pointers and occupancy; pop only ever sees entries pushed on earlier edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus next values of every registered controller/response output.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    c_op_d       = NOP_OP;
    c_start_d    = 1'b0;
    c_data_d     = c_data_q;
    op_d         = op_q;
    wait_d       = wait_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_op_d     = rsp_op_q;
    rsp_err_d    = rsp_err_q;
    issued_cnt_d = issued_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && bus.ready && !rsp_valid_q) begin
          state_d      = ISSUE;
          pop          = 1'b1;
          c_op_d       = head.op;
          c_data_d     = head.data;
          c_start_d    = head.start;
          op_d         = head.op;
          issued_cnt_d = issued_cnt_q + 16'd1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: begin
        // A ready controller on the limit cycle still reports its own error code.
        if (bus.ready) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_op_d    = op_q;
          rsp_err_d   = bus.err;
        end else if (wait_q == WAIT_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_op_d    = op_q;
          rsp_err_d   = ERR_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_op_q       <= NOP_OP;
      c_data_q     <= '0;
      c_start_q    <= 1'b0;
      op_q         <= '0;
      wait_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= '0;
      rsp_err_q    <= '0;
      issued_cnt_q <= '0;
    end else begin
      c_op_q       <= c_op_d;
      c_data_q     <= c_data_d;
      c_start_q    <= c_start_d;
      op_q         <= op_d;
      wait_q       <= wait_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_err_q    <= rsp_err_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign bus.cmd_ready  = !fifo_full;
  assign bus.C_op       = c_op_q;
  assign bus.C_data     = c_data_q;
  assign bus.C_start    = c_start_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = (state_q != IDLE) || !fifo_empty;
  assign bus.issued_cnt = issued_cnt_q;

endmodule

// File: tb/tb_bids_cmd_sequencer.sv
// Randomized and directed bench for bids_cmd_sequencer, compared every cycle against
// a transaction-level model of the queue, issue slot and completion timing.
module tb_bids_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 16;

  logic clk;
  logic reset;

  bids_cmd_sequencer_if bus ();

  bids_cmd_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TO),
    .NOP_OP     (4'hF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] data;
    logic        start;
  } ent_t;

  int n_chk;
  int n_fail;

  // Model: pending commands, which step of the command lifetime we are in, and
  // how many cycles have been spent waiting for the controller.
  ent_t        q[$];
  int          stage;      // 0 idle, 1 issue cycle, 2 waiting, 3 response pending
  int          waited;
  ent_t        cur;
  logic [31:0] m_cdata;
  logic        m_rv;
  logic [3:0]  m_rop;
  logic [2:0]  m_rerr;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    stage   = 0;
    waited  = 0;
    cur     = '{op: 4'h0, data: 32'h0, start: 1'b0};
    m_cdata = 32'h0;
    m_rv    = 1'b0;
    m_rop   = 4'h0;
    m_rerr  = 3'h0;
    m_cnt   = 16'h0;
  endtask

  task automatic check_all();
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(q.size() < DEPTH));
    chk("C_op", 32'(bus.C_op), (stage == 1) ? 32'(cur.op) : 32'hF);
    chk("C_start", 32'(bus.C_start), (stage == 1) ? 32'(cur.start) : 32'h0);
    chk("C_data", bus.C_data, m_cdata);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rv));
    if (m_rv) begin
      chk("rsp_op", 32'(bus.rsp_op), 32'(m_rop));
      chk("rsp_err", 32'(bus.rsp_err), 32'(m_rerr));
    end
    chk("busy", 32'(bus.busy), 32'((stage != 0) || (q.size() != 0)));
    chk("issued_cnt", 32'(bus.issued_cnt), 32'(m_cnt));
  endtask

  // Advance the model by one clock edge given the inputs held during that cycle.
  task automatic model_update(input logic cv, input ent_t e_in, input logic rdy,
                              input logic [2:0] e, input logic rr);
    logic accept;
    accept = cv && (q.size() < DEPTH);
    case (stage)
      0: if (q.size() > 0 && rdy && !m_rv) begin
           cur     = q.pop_front();
           m_cdata = cur.data;
           m_cnt   = m_cnt + 16'd1;
           stage   = 1;
         end
      1: begin
           stage  = 2;
           waited = 0;
         end
      2: begin
           waited = waited + 1;
           if (rdy || waited == TO) begin
             m_rv   = 1'b1;
             m_rop  = cur.op;
             m_rerr = rdy ? e : 3'b111;
             stage  = 3;
           end
         end
      default: if (rr) begin
           m_rv  = 1'b0;
           stage = 0;
         end
    endcase
    if (accept) q.push_back(e_in);
  endtask

  // One cycle: check outputs at the falling edge, drive new inputs, advance the model.
  task automatic step(input logic cv, input logic [3:0] op, input logic [31:0] d,
                      input logic st, input logic rdy, input logic [2:0] e, input logic rr);
    ent_t ent;
    check_all();
    bus.cmd_valid = cv;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_start = st;
    bus.ready     = rdy;
    bus.err       = e;
    bus.rsp_ready = rr;
    ent = '{op: op, data: d, start: st};
    model_update(cv, ent, rdy, e, rr);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy, input logic rr);
    step(1'b0, 4'h0, 32'h0, 1'b0, rdy, 3'b000, rr);
  endtask

  // Reset asserted mid-cycle; outputs must follow immediately, before any clock edge.
  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    bus.ready     = 1'b0;
    bus.rsp_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    chk("rst_C_op", 32'(bus.C_op), 32'hF);
    chk("rst_C_data", bus.C_data, 32'h0);
    chk("rst_C_start", 32'(bus.C_start), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_op", 32'(bus.rsp_op), 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_issued_cnt", 32'(bus.issued_cnt), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] base;
    logic        pend;
    int          p_rdy;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'h0;
    bus.cmd_data  = 32'h0;
    bus.cmd_start = 1'b0;
    bus.ready     = 1'b0;
    bus.err       = 3'b000;
    bus.rsp_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single command, controller ready immediately.
    step(1'b1, 4'b0010, 32'hA5A5_0001, 1'b0, 1'b1, 3'b000, 1'b0);
    idle(1'b1, 1'b0);
    chk("single_C_op", 32'(bus.C_op), 32'h2);
    chk("single_C_data", bus.C_data, 32'hA5A5_0001);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("single_rsp_op", 32'(bus.rsp_op), 32'h2);
    chk("single_rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("single_cnt", 32'(bus.issued_cnt), 32'h1);
    idle(1'b0, 1'b1);

    // Controller never answers: timeout on the 16th waiting cycle.
    step(1'b1, 4'b0110, 32'h1234_5678, 1'b1, 1'b1, 3'b000, 1'b0);
    idle(1'b1, 1'b0);
    repeat (16) idle(1'b0, 1'b0);
    chk("to_not_yet", 32'(bus.rsp_valid), 32'h0);
    idle(1'b0, 1'b0);
    chk("to_fire", 32'(bus.rsp_valid), 32'h1);
    repeat (3) idle(1'b0, 1'b0);
    chk("to_err", 32'(bus.rsp_err), 32'h7);
    chk("to_C_op", 32'(bus.C_op), 32'hF);
    idle(1'b0, 1'b1);

    // Controller becomes ready exactly on the limit cycle.
    step(1'b1, 4'b1001, 32'hCAFE_0002, 1'b0, 1'b1, 3'b000, 1'b0);
    idle(1'b1, 1'b0);
    repeat (16) idle(1'b0, 1'b0);
    step(1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 3'b010, 1'b0);
    chk("edge_valid", 32'(bus.rsp_valid), 32'h1);
    chk("edge_err", 32'(bus.rsp_err), 32'h2);
    idle(1'b0, 1'b1);

    // Fill the queue while the controller is busy; the fifth push stalls.
    base = bus.issued_cnt;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'(i + 1), 32'hB000_0000 + 32'(i), 1'(i), 1'b0, 3'b000, 1'b1);
    end
    chk("full_cmd_ready", 32'(bus.cmd_ready), 32'h0);
    step(1'b1, 4'h5, 32'hB000_0004, 1'b1, 1'b0, 3'b000, 1'b1);
    chk("full_still", 32'(bus.cmd_ready), 32'h0);
    pend = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic take;
      take = pend && (q.size() < DEPTH);
      step(pend, 4'h5, 32'hB000_0004, 1'b1, 1'b1, 3'b001, 1'b1);
      if (take) pend = 1'b0;
    end
    chk("b2b_cnt", 32'(bus.issued_cnt), 32'(base + 16'd5));

    // Response held by the host blocks the next issue.
    base = bus.issued_cnt;
    step(1'b1, 4'hA, 32'hD000_0001, 1'b0, 1'b1, 3'b011, 1'b0);
    step(1'b1, 4'hB, 32'hD000_0002, 1'b0, 1'b1, 3'b011, 1'b0);
    repeat (15) idle(1'b1, 1'b0);
    chk("hold_cnt", 32'(bus.issued_cnt), 32'(base + 16'd1));
    chk("hold_op", 32'(bus.rsp_op), 32'hA);
    repeat (10) idle(1'b1, 1'b1);
    chk("hold_cnt2", 32'(bus.issued_cnt), 32'(base + 16'd2));

    // Reset while waiting with two commands still queued.
    step(1'b1, 4'h3, 32'hE000_0001, 1'b1, 1'b0, 3'b000, 1'b1);
    step(1'b1, 4'h4, 32'hE000_0002, 1'b1, 1'b0, 3'b000, 1'b1);
    step(1'b1, 4'h5, 32'hE000_0003, 1'b1, 1'b1, 3'b000, 1'b1);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    do_reset();
    repeat (10) idle(1'b1, 1'b1);
    chk("post_rst_cnt", 32'(bus.issued_cnt), 32'h0);
    chk("post_rst_C_op", 32'(bus.C_op), 32'hF);

    // Random traffic with the controller's readiness varied in bursts.
    p_rdy = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       p_rdy = 90;
          1:       p_rdy = 40;
          default: p_rdy = 3;
        endcase
      end
      step(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 1'($urandom),
           1'($urandom_range(0, 99) < p_rdy), 3'($urandom), 1'($urandom_range(0, 99) < 70));
    end
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
